tlcd_divisor_sequencer: RTL and testbench



---
 rtl/tlcd_divisor_sequencer_if.sv | 37 +++
 rtl/tlcd_divisor_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_tlcd_divisor_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlcd_divisor_sequencer_if.sv
// rtl/tlcd_divisor_sequencer_if.sv - requester, quiesce and TileLink A/D bundle for the divisor sequencer
interface tlcd_divisor_sequencer_if #(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 21,
  parameter int SOURCE_W = 11
);
  logic [N_REQ-1:0]    req_valid;
  logic [8*N_REQ-1:0]  req_divisor;
  logic [N_REQ-1:0]    req_ready;
  logic                quiesce_req;
  logic                quiesce_ack;
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [1:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [7:0]          a_mask;
  logic [63:0]         a_data;
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [63:0]         d_data;

  modport master (
    input  req_valid, req_divisor, quiesce_ack, a_ready, d_valid, d_opcode, d_data,
    output req_ready, quiesce_req, a_valid, a_opcode, a_param, a_size, a_source,
           a_address, a_mask, a_data, d_ready
  );

  modport slave (
    output req_valid, req_divisor, quiesce_ack, a_ready, d_valid, d_opcode, d_data,
    input  req_ready, quiesce_req, a_valid, a_opcode, a_param, a_size, a_source,
           a_address, a_mask, a_data, d_ready
  );
endinterface

// File: rtl/tlcd_divisor_sequencer.sv
// rtl/tlcd_divisor_sequencer.sv - round-robin divisor change sequencer with quiesce, PutFull and settle window
// Optional read-back verify of the written divisor: define TLCD_SEQ_VERIFY_EN.
module tlcd_divisor_sequencer #(
  parameter int               N_REQ         = 2,
  parameter int               ADDR_W        = 21,
  parameter int               SOURCE_W      = 11,
  parameter logic [ADDR_W-1:0] DIV_REG_ADDR = '0,
  parameter int               SOURCE_ID     = 0,
  parameter int               SETTLE_CYCLES = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  tlcd_divisor_sequencer_if.master  bus,
  output logic [7:0]                cur_divisor_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [2:0]                done_id_o,
  output logic                      err_o
);

`ifdef TLCD_SEQ_VERIFY_EN
  typedef enum logic [2:0] {IDLE, QUIESCE, PUT, WAIT_D, VERIFY_A, VERIFY_D, SETTLE, RELEASE} state_e;
  logic [7:0] prev_q, prev_d;
`else
  typedef enum logic [2:0] {IDLE, QUIESCE, PUT, WAIT_D, SETTLE, RELEASE} state_e;
  logic unused_d_data;
  assign unused_d_data = ^bus.d_data;
`endif

  state_e     state_q, state_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] gid_q, gid_d;
  logic [7:0] div_q, div_d;
  logic [7:0] cur_q, cur_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] gnt_rot;
  logic [3:0]       gnt_sum;
  logic             gnt_found;
  logic [2:0]       gnt_idx;
  logic [7:0]       gnt_div;

  // Rotating the request vector by rr_ptr turns "first valid at or after rr_ptr" into a plain priority scan.
  assign gnt_rot = N_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_sum   = '0;
    gnt_div   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && gnt_rot[i]) begin
        gnt_found = 1'b1;
        gnt_sum   = {1'b0, rr_ptr_q} + 4'(i);
        if (gnt_sum >= 4'(N_REQ)) gnt_sum = gnt_sum - 4'(N_REQ);
        gnt_idx   = gnt_sum[2:0];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt_idx == 3'(j)) gnt_div = bus.req_divisor[8*j +: 8];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      div_q    <= '0;
      cur_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef TLCD_SEQ_VERIFY_EN
      prev_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      div_q    <= div_d;
      cur_q    <= cur_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef TLCD_SEQ_VERIFY_EN
      prev_q   <= prev_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    gid_d           = gid_q;
    div_d           = div_q;
    cur_d           = cur_q;
    err_d           = err_q;
    cnt_d           = '0;
`ifdef TLCD_SEQ_VERIFY_EN
    prev_d          = prev_q;
`endif
    bus.req_ready   = '0;
    bus.quiesce_req = 1'b0;
    bus.a_valid     = 1'b0;
    bus.a_opcode    = 3'd0;
    bus.d_ready     = 1'b0;
    done_o          = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          bus.req_ready = N_REQ'(1) << gnt_idx;
          div_d         = gnt_div;
          gid_d         = gnt_idx;
          err_d         = 1'b0;
          rr_ptr_d      = (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
          state_d       = (gnt_div == cur_q) ? RELEASE : QUIESCE;
        end
      end
      QUIESCE: begin
        bus.quiesce_req = 1'b1;
        if (bus.quiesce_ack) state_d = PUT;
      end
      PUT: begin
        bus.quiesce_req = 1'b1;
        bus.a_valid     = 1'b1;
        if (bus.a_ready) state_d = WAIT_D;
      end
      WAIT_D: begin
        bus.quiesce_req = 1'b1;
        bus.d_ready     = 1'b1;
        if (bus.d_valid) begin
          if (bus.d_opcode == 3'd0) begin
            cur_d   = div_q;
`ifdef TLCD_SEQ_VERIFY_EN
            prev_d  = cur_q;
            state_d = VERIFY_A;
`else
            state_d = SETTLE;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = SETTLE;
          end
        end
      end
`ifdef TLCD_SEQ_VERIFY_EN
      VERIFY_A: begin
        bus.quiesce_req = 1'b1;
        bus.a_valid     = 1'b1;
        bus.a_opcode    = 3'd4;
        if (bus.a_ready) state_d = VERIFY_D;
      end
      VERIFY_D: begin
        bus.quiesce_req = 1'b1;
        bus.d_ready     = 1'b1;
        if (bus.d_valid) begin
          if (bus.d_opcode != 3'd1 || bus.d_data[7:0] != div_q) begin
            err_d = 1'b1;
            cur_d = prev_q;
          end
          state_d = SETTLE;
        end
      end
`endif
      SETTLE: begin
        bus.quiesce_req = 1'b1;
        if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_d = RELEASE;
        else                                cnt_d   = cnt_q + 8'd1;
      end
      RELEASE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.a_param   = 3'd0;
  assign bus.a_size    = 2'd0;
  assign bus.a_source  = SOURCE_W'(SOURCE_ID);
  assign bus.a_address = DIV_REG_ADDR;
  assign bus.a_mask    = 8'h01;
  assign bus.a_data    = {56'h0, div_q};

  assign cur_divisor_o = cur_q;
  assign busy_o        = (state_q != IDLE);
  assign done_id_o     = gid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_tlcd_divisor_sequencer.sv
// tb/tb_tlcd_divisor_sequencer.sv - self-checking bench for tlcd_divisor_sequencer
module tb_tlcd_divisor_sequencer;
  localparam int N_REQ  = 2;
  localparam int SETTLE = 16;
`ifdef TLCD_SEQ_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlcd_divisor_sequencer_if #(.N_REQ(N_REQ), .ADDR_W(21), .SOURCE_W(11)) bus ();

  logic [7:0] cur_div;
  logic       busy, done, err;
  logic [2:0] done_id;

  tlcd_divisor_sequencer #(
    .N_REQ(N_REQ), .ADDR_W(21), .SOURCE_W(11), .DIV_REG_ADDR(21'h0),
    .SOURCE_ID(0), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock_i(clk), .reset_i(rst), .bus(bus), .cur_divisor_o(cur_div),
    .busy_o(busy), .done_o(done), .done_id_o(done_id), .err_o(err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         q_delay = 0;
  int         a_delay = 0;
  logic [2:0] d_opc_knob = 3'd0;
  bit         bad_get = 1'b0;

  int          fire_cnt = 0, a_seen = 0, q_seen = 0, viol = 0;
  logic [63:0] last_a_data;
  logic [7:0]  last_a_mask;
  logic [20:0] last_a_addr;
  logic [2:0]  last_a_opcode, last_a_param;
  logic [1:0]  last_a_size;
  logic [10:0] last_a_source;
  int gnt_q[$], gnt_cyc_q[$], done_id_q[$], done_cyc_q[$];

  int         m_rr = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave side: quiesce and TL responders with programmable latency, plus a one-register divider model.
  initial begin
    int qcnt, acnt;
    bit last_get;
    logic [7:0] slave_reg;
    qcnt = 0; acnt = 0; last_get = 1'b0; slave_reg = 8'h00;
    bus.req_valid = '0; bus.req_divisor = '0; bus.quiesce_ack = 1'b0; bus.a_ready = 1'b0;
    bus.d_valid = 1'b0; bus.d_opcode = 3'd0; bus.d_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        qcnt = 0; acnt = 0;
        bus.quiesce_ack = 1'b0; bus.a_ready = 1'b0; bus.d_valid = 1'b0;
      end else begin
        if (bus.quiesce_req) begin
          bus.quiesce_ack = (qcnt >= q_delay);
          qcnt++;
        end else begin
          qcnt = 0;
          bus.quiesce_ack = 1'b0;
        end
        if (bus.a_valid) begin
          bus.a_ready = (acnt >= a_delay);
          acnt++;
        end else begin
          acnt = 0;
          bus.a_ready = 1'b0;
        end
        bus.d_valid  = bus.d_ready;
        bus.d_opcode = last_get ? 3'd1 : d_opc_knob;
        bus.d_data   = last_get ? {56'h0, (bad_get ? 8'h07 : slave_reg)} : 64'h0;
        if (bus.a_valid && bus.a_ready) begin
          last_get = (bus.a_opcode == 3'd4);
          if (!last_get) slave_reg = bus.a_data[7:0];
        end
      end
    end
  end

  initial begin
    bit          ack_seen, prev_stall;
    logic [63:0] p_data;
    logic [2:0]  p_opc;
    int          gi;
    ack_seen = 1'b0; prev_stall = 1'b0; p_data = '0; p_opc = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        ack_seen = 1'b0; prev_stall = 1'b0;
      end else begin
        if (|bus.req_ready) begin
          if (!$onehot(bus.req_ready)) viol++;
          gi = 0;
          for (int k = 0; k < N_REQ; k++) if (bus.req_ready[k]) gi = k;
          gnt_q.push_back(gi);
          gnt_cyc_q.push_back(cyc);
        end
        if (!bus.quiesce_req) ack_seen = 1'b0;
        if (bus.quiesce_req) q_seen++;
        if (bus.a_valid) begin
          a_seen++;
          if (!bus.quiesce_req || !ack_seen) viol++;
          if (prev_stall && (bus.a_data !== p_data || bus.a_opcode !== p_opc)) viol++;
        end
        if (bus.quiesce_req && bus.quiesce_ack) ack_seen = 1'b1;
        prev_stall = bus.a_valid && !bus.a_ready;
        p_data = bus.a_data;
        p_opc  = bus.a_opcode;
        if (bus.a_valid && bus.a_ready) begin
          fire_cnt++;
          last_a_data = bus.a_data; last_a_mask = bus.a_mask; last_a_addr = bus.a_address;
          last_a_opcode = bus.a_opcode; last_a_param = bus.a_param; last_a_size = bus.a_size;
          last_a_source = bus.a_source;
        end
        if (done) begin
          done_id_q.push_back(int'(done_id));
          done_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic model_grant(input logic [N_REQ-1:0] v, output int g);
    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int c;
      c = (m_rr + k) % N_REQ;
      if (g < 0 && v[c]) g = c;
    end
    m_rr = (g + 1) % N_REQ;
  endtask

  task automatic do_op(input string tag, input logic [N_REQ-1:0] vmask, input logic [7:0] d0, input logic [7:0] d1);
    int g_before, d_before, f_before, a_before, q_before, budget, eg, elat, efire, gv, dv, lat;
    bit skip, ok_put, ok_all;
    logic [7:0] ediv;
    g_before = gnt_q.size(); d_before = done_id_q.size();
    f_before = fire_cnt; a_before = a_seen; q_before = q_seen;
    model_grant(vmask, eg);
    ediv   = (eg == 0) ? d0 : d1;
    skip   = (ediv == m_cur);
    ok_put = (d_opc_knob == 3'd0);
    ok_all = ok_put && !(VER && bad_get);
    if (skip) begin
      elat = 1; efire = 0;
      m_err = 1'b0;
    end else begin
      elat  = 4 + SETTLE + q_delay + a_delay + ((VER && ok_put) ? 2 + a_delay : 0);
      efire = (VER && ok_put) ? 2 : 1;
      if (ok_all) m_cur = ediv;
      m_err = !ok_all;
    end

    @(negedge clk);
    bus.req_divisor = {d1, d0};
    bus.req_valid   = vmask;
    budget = 200;
    #4;
    while (gnt_q.size() == g_before && budget > 0) begin
      @(negedge clk); #4; budget--;
    end
    check({tag, "_grant_seen"}, 64'(budget > 0), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    budget = 500;
    while (done_id_q.size() == d_before && budget > 0) begin
      @(negedge clk); #4; budget--;
    end
    check({tag, "_done_seen"}, 64'(budget > 0), 64'd1);

    gv  = (gnt_q.size() > g_before) ? gnt_q[g_before] : -1;
    dv  = (done_id_q.size() > d_before) ? done_id_q[d_before] : -1;
    lat = (gnt_q.size() > g_before && done_id_q.size() > d_before) ?
          done_cyc_q[d_before] - gnt_cyc_q[g_before] : -1;
    check({tag, "_grant_idx"}, 64'(gv), 64'(eg));
    check({tag, "_done_id"}, 64'(dv), 64'(eg));
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_cur_div"}, 64'(cur_div), 64'(m_cur));
    check({tag, "_err"}, 64'(err), 64'(m_err));
    check({tag, "_fires"}, 64'(fire_cnt - f_before), 64'(efire));
    check({tag, "_a_valid_cycles"}, 64'(a_seen - a_before), skip ? 64'd0 : 64'(efire * (a_delay + 1)));
    check({tag, "_quiesce_cycles"}, 64'(q_seen - q_before), skip ? 64'd0 : 64'(elat - 1));
    if (!skip) begin
      check({tag, "_a_data"}, last_a_data, {56'h0, ediv});
      check({tag, "_a_fields"}, {last_a_mask, 3'b0, last_a_addr, 1'b0, last_a_param, 2'b0, last_a_size, 5'b0, last_a_source},
            {8'h01, 3'b0, 21'h0, 1'b0, 3'd0, 2'b0, 2'd0, 5'b0, 11'd0});
      check({tag, "_a_opcode"}, 64'(last_a_opcode), (VER && ok_put) ? 64'd4 : 64'd0);
    end
  endtask

  initial begin
    int g_before, d_before, budget, eg, dc;
    logic [7:0] rd0, rd1;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outputs", {cur_div, done, err, bus.a_valid, bus.quiesce_req, bus.d_ready, 6'(bus.req_ready)},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
    rst = 1'b0;

    do_op("single", 2'b01, 8'h04, 8'h09);
    do_op("skip", 2'b10, 8'h55, 8'h04);

    g_before = gnt_q.size(); d_before = done_id_q.size();
    @(negedge clk);
    bus.req_divisor = {8'h03, 8'h02};
    bus.req_valid   = 2'b11;
    budget = 1000;
    while (done_id_q.size() < d_before + 4 && budget > 0) begin
      @(negedge clk); #4; budget--;
    end
    bus.req_valid = '0;
    check("rr_done_seen", 64'(budget > 0), 64'd1);
    check("rr_grant_count", 64'(gnt_q.size() - g_before), 64'd4);
    for (int n = 0; n < 4; n++) begin
      model_grant(2'b11, eg);
      if (gnt_q.size() > g_before + n && done_id_q.size() > d_before + n) begin
        check($sformatf("rr_grant%0d", n), 64'(gnt_q[g_before + n]), 64'(eg));
        check($sformatf("rr_done_id%0d", n), 64'(done_id_q[d_before + n]), 64'(eg));
        check($sformatf("rr_latency%0d", n), 64'(done_cyc_q[d_before + n] - gnt_cyc_q[g_before + n]),
              64'(4 + SETTLE + (VER ? 2 : 0)));
        if (n > 0) check($sformatf("rr_back_to_back%0d", n), 64'(gnt_cyc_q[g_before + n]),
                         64'(done_cyc_q[d_before + n - 1] + 1));
      end
      m_cur = (eg == 0) ? 8'h02 : 8'h03;
    end
    check("rr_cur_div", 64'(cur_div), 64'(m_cur));

    q_delay = 10; a_delay = 5;
    do_op("backpressure", 2'b01, 8'h21, 8'h00);
    q_delay = 0; a_delay = 0;

    d_opc_knob = 3'd2;
    do_op("d_error", 2'b10, 8'h00, 8'h66);
    d_opc_knob = 3'd0;

`ifdef TLCD_SEQ_VERIFY_EN
    do_op("pre_verify", 2'b01, 8'h09, 8'h09);
    bad_get = 1'b1;
    do_op("verify_bad", 2'b01, 8'h05, 8'h05);
    bad_get = 1'b0;
`endif

    for (int r = 0; r < 6; r++) begin
      q_delay    = $urandom_range(0, 3);
      a_delay    = $urandom_range(0, 3);
      d_opc_knob = ($urandom_range(0, 3) == 0) ? 3'd2 : 3'd0;
      rd0 = 8'($urandom_range(0, 255));
      rd1 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rd0 = m_cur;
      do_op($sformatf("rand%0d", r), 2'($urandom_range(1, 3)), rd0, rd1);
    end
    q_delay = 0; d_opc_knob = 3'd0;

    a_delay = 40;
    rd0 = m_cur ^ 8'h5A;
    dc = done_id_q.size();
    model_grant(2'b01, eg);
    @(negedge clk);
    bus.req_divisor = {8'h00, rd0};
    bus.req_valid   = 2'b01;
    budget = 100;
    #4;
    while (!bus.a_valid && budget > 0) begin
      @(negedge clk); #4; budget--;
    end
    check("rst_put_reached", 64'(budget > 0), 64'd1);
    bus.req_valid = '0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_drop", {61'h0, bus.a_valid, bus.quiesce_req, busy}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    a_delay = 0;
    m_cur = 8'h00; m_rr = 0; m_err = 1'b0;
    #1;
    check("rst_after_cur", 64'(cur_div), 64'd0);
    check("rst_after_busy_err", {busy, err}, 64'd0);
    repeat (5) @(negedge clk);
    check("rst_no_done", 64'(done_id_q.size()), 64'(dc));
    do_op("rr_ptr_after_rst", 2'b11, 8'h07, 8'h08);

    check("protocol_violations", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
